h_matrix_loader: RTL and testbench

H_MATRIX_LOADER -- requirements
Module: h_matrix_loader

---
 rtl/ldpc_pkg.sv | 8 +
 rtl/ldpc_lat_pipe.sv | 29 ++
 rtl/h_matrix_loader.sv | 97 +++++++++
 tb/tb_h_matrix_loader.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared loader FSM state type and default H-matrix geometry
package ldpc_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} ld_state_e;
  localparam int DEF_ROW_W   = 162;
  localparam int DEF_N_ROWS  = 27;
  localparam int DEF_RPW     = 9;
  localparam int DEF_N_MODES = 4;
endpackage

// File: rtl/ldpc_lat_pipe.sv
// ldpc_lat_pipe: DEPTH-stage valid/payload delay line matching the ROM read latency
module ldpc_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);
  logic [DEPTH-1:0]        vld_q;
  logic [DEPTH-1:0][W-1:0] dat_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      dat_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  assign vld_o = vld_q[DEPTH-1];
  assign dat_o = dat_q[DEPTH-1];
endmodule

// File: rtl/h_matrix_loader.sv
// h_matrix_loader: streams one code-rate H matrix out of an external ROM into a row register file
module h_matrix_loader import ldpc_pkg::*; #(
  parameter int ROW_W   = DEF_ROW_W,
  parameter int N_ROWS  = DEF_N_ROWS,
  parameter int RPW     = DEF_RPW,
  parameter int N_MODES = DEF_N_MODES,
  parameter int ROM_LAT = 1,
  parameter int WPM     = N_ROWS / RPW,
  parameter int MW      = $clog2(N_MODES),
  parameter int AW      = $clog2(N_MODES * WPM)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_req,
  input  logic [MW-1:0]                 load_mode,
  output logic                          rom_en,
  output logic [AW-1:0]                 rom_addr,
  input  logic [RPW*ROW_W-1:0]          rom_dout,
  output logic [N_ROWS-1:0][ROW_W-1:0]  H2,
  output logic [MW-1:0]                 h_mode,
  output logic                          h_valid,
  output logic                          busy,
  output logic                          load_done,
  output logic                          load_err
);
  localparam int IW = WPM > 1 ? $clog2(WPM) : 1;
  if (N_ROWS % RPW != 0) begin : g_bad_rpw
    $error("N_ROWS must be a multiple of RPW");
  end
  if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_lat
    $error("ROM_LAT must lie in 1..4");
  end
  ld_state_e                   state_q;
  logic [MW-1:0]               mode_q, h_mode_q;
  logic [IW-1:0]               k_q, pidx;
  logic [N_ROWS-1:0][ROW_W-1:0] h2_q;
  logic                        h_valid_q, done_q, err_q, pv, req_ok, last_word;
  assign req_ok    = load_req && 32'(load_mode) < N_MODES;
  assign last_word = pv && pidx == IW'(WPM - 1);
  assign rom_en    = state_q == FETCH;
  assign rom_addr  = rom_en ? AW'(32'(mode_q) * WPM + 32'(k_q)) : '0;
  // the pipe carries the word index alongside valid so returned data lands in the right rows
  ldpc_lat_pipe #(.DEPTH(ROM_LAT), .W(IW)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .vld_i(rom_en),
    .dat_i(k_q),
    .vld_o(pv),
    .dat_o(pidx)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      h_mode_q  <= '0;
      k_q       <= '0;
      h2_q      <= '0;
      h_valid_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE:
          if (load_req) begin
            if (req_ok) begin
              state_q   <= FETCH;
              mode_q    <= load_mode;
              k_q       <= '0;
              h_valid_q <= 1'b0;
            end else
              err_q <= 1'b1;
          end
        FETCH: begin
          k_q <= k_q + IW'(1);
          if (k_q == IW'(WPM - 1)) state_q <= DRAIN;
        end
        DRAIN:
          if (last_word) begin
            state_q   <= IDLE;
            h_valid_q <= 1'b1;
            h_mode_q  <= mode_q;
            done_q    <= 1'b1;
          end
        default: state_q <= IDLE;
      endcase
      for (int r = 0; r < N_ROWS; r++)
        if (pv && r / RPW == int'(pidx)) h2_q[r] <= rom_dout[(r % RPW) * ROW_W +: ROW_W];
    end
  assign H2        = h2_q;
  assign h_mode    = h_mode_q;
  assign h_valid   = h_valid_q;
  assign busy      = state_q != IDLE;
  assign load_done = done_q;
  assign load_err  = err_q;
endmodule

// File: tb/tb_h_matrix_loader.sv
// tb_h_matrix_loader: directed loads against two loader configurations with a behavioural ROM and scoreboard
module tb_h_matrix_loader;
  localparam int ROW_W = 162;
  localparam int NR    = 27;
  typedef struct {int mode; int cyc;} exp_t;
  logic clk = 1'b0, rst;
  logic load_req0, load_req1, rom_en0, rom_en1;
  logic h_valid0, h_valid1, busy0, busy1, load_done0, load_done1, load_err0, load_err1;
  logic [2:0] load_mode0, h_mode0;
  logic [1:0] load_mode1, h_mode1;
  logic [3:0] rom_addr0, ra0;
  logic [1:0] rom_addr1;
  logic [1:0] ra1 [3];
  logic [9*ROW_W-1:0]  rom_dout0;
  logic [27*ROW_W-1:0] rom_dout1, w0;
  logic [NR-1:0][ROW_W-1:0] H2_0, H2_1;
  exp_t q0[$], q1[$];
  int cyc = 0, n_checks = 0, n_err = 0, c;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  h_matrix_loader #(.MW(3)) u0 (
    .clk(clk), .rst(rst), .load_req(load_req0), .load_mode(load_mode0),
    .rom_en(rom_en0), .rom_addr(rom_addr0), .rom_dout(rom_dout0), .H2(H2_0),
    .h_mode(h_mode0), .h_valid(h_valid0), .busy(busy0), .load_done(load_done0), .load_err(load_err0));
  h_matrix_loader #(.RPW(27), .ROM_LAT(3)) u1 (
    .clk(clk), .rst(rst), .load_req(load_req1), .load_mode(load_mode1),
    .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_dout(rom_dout1), .H2(H2_1),
    .h_mode(h_mode1), .h_valid(h_valid1), .busy(busy1), .load_done(load_done1), .load_err(load_err1));
  function automatic logic [ROW_W-1:0] row_val(int a, int j);
    logic [191:0] t;
    for (int i = 0; i < 6; i++) t[i*32 +: 32] = 32'(a * 97 + j * 13 + i * 7 + 1) * 32'h9E3779B1;
    return t[ROW_W-1:0];
  endfunction
  function automatic logic [27*ROW_W-1:0] rom_word(int a, int rpw);
    logic [27*ROW_W-1:0] w = '0;
    for (int j = 0; j < rpw; j++) w[j*ROW_W +: ROW_W] = row_val(a, j);
    return w;
  endfunction
  function automatic int bad_rows(logic [NR-1:0][ROW_W-1:0] h, int mode, int rpw, bit zero);
    int n = 0;
    for (int r = 0; r < NR; r++)
      if (h[r] !== (zero ? '0 : row_val(mode * (NR / rpw) + r / rpw, r % rpw))) n++;
    return n;
  endfunction
  always @(posedge clk) begin
    ra0    <= rom_addr0;
    ra1[0] <= rom_addr1;
    ra1[1] <= ra1[0];
    ra1[2] <= ra1[1];
  end
  always_comb w0 = rom_word(int'(ra0), 9);
  assign rom_dout0 = w0[9*ROW_W-1:0];
  assign rom_dout1 = rom_word(int'(ra1[2]), 27);
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 40 && (q0.size() + q1.size() != 0 || busy0 || busy1); i++) @(negedge clk);
    chk("idle_timeout", q0.size() + q1.size(), 0);
  endtask
  always @(negedge clk) begin
    if (load_done0) begin
      chk("u0_done_expected", q0.size() > 0, 1);
      if (q0.size() > 0) begin
        exp_t e;
        e = q0.pop_front();
        chk("u0_done_cycle", cyc, e.cyc);
        chk("u0_h_mode", h_mode0, e.mode);
        chk("u0_h_valid", h_valid0, 1);
        chk("u0_rows", bad_rows(H2_0, e.mode, 9, 0), 0);
      end
    end
    if (load_done1) begin
      chk("u1_done_expected", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        exp_t e;
        e = q1.pop_front();
        chk("u1_done_cycle", cyc, e.cyc);
        chk("u1_h_mode", h_mode1, e.mode);
        chk("u1_rows", bad_rows(H2_1, e.mode, 27, 0), 0);
      end
    end
  end
  initial begin
    rst = 1'b0;
    load_req0 = 1'b0; load_mode0 = '0; load_req1 = 1'b0; load_mode1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_h_valid", h_valid0, 0);
    chk("rst_h_mode", h_mode0, 0);
    chk("rst_rom_en", rom_en0, 0);
    chk("rst_rom_addr", rom_addr0, 0);
    chk("rst_done_err", {load_done0, load_err0}, 0);
    chk("rst_rows", bad_rows(H2_0, 0, 9, 1), 0);
    chk("rst_u1_rows", bad_rows(H2_1, 0, 27, 1), 0);
    rst = 1'b1;
    @(negedge clk); c = cyc; load_req1 = 1'b1; load_mode1 = 2; q1.push_back(exp_t'{2, c + 5});
    @(negedge clk); load_req1 = 1'b0;
    chk("u1_rom_en", rom_en1, 1);
    chk("u1_rom_addr", rom_addr1, 2);
    @(negedge clk);
    chk("u1_rom_en_drain", rom_en1, 0);
    chk("u1_busy", busy1, 1);
    repeat (2) @(negedge clk);
    chk("u1_rows_before_done", bad_rows(H2_1, 0, 27, 1), 0);
    chk("u1_h_valid_load", h_valid1, 0);
    wait_idle();
    @(negedge clk); c = cyc; load_req0 = 1'b1; load_mode0 = 2; q0.push_back(exp_t'{2, c + 5});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); load_req0 = 1'b0;
      chk("u0_rom_en", rom_en0, 1);
      chk("u0_rom_addr", rom_addr0, 6 + k);
      chk("u0_h_valid_load", h_valid0, 0);
    end
    @(negedge clk);
    chk("u0_rom_en_drain", rom_en0, 0);
    chk("u0_rom_addr_drain", rom_addr0, 0);
    chk("u0_busy_drain", busy0, 1);
    wait_idle();
    @(negedge clk); load_req0 = 1'b1; load_mode0 = 5;
    @(negedge clk); load_req0 = 1'b0;
    chk("err_pulse", load_err0, 1);
    chk("err_busy", busy0, 0);
    @(negedge clk);
    chk("err_single", load_err0, 0);
    chk("err_h_valid", h_valid0, 1);
    chk("err_h_mode", h_mode0, 2);
    chk("err_rows", bad_rows(H2_0, 2, 9, 0), 0);
    @(negedge clk); c = cyc; load_req0 = 1'b1; load_mode0 = 1;
    q0.push_back(exp_t'{1, c + 5}); q0.push_back(exp_t'{0, c + 10});
    @(negedge clk); load_mode0 = 0;
    repeat (5) @(negedge clk);
    chk("held_h_valid", h_valid0, 0);
    chk("held_busy", busy0, 1);
    chk("held_rom_en", rom_en0, 1);
    chk("held_rom_addr", rom_addr0, 0);
    load_req0 = 1'b0;
    wait_idle();
    @(negedge clk); load_req0 = 1'b1; load_mode0 = 3;
    @(negedge clk); load_req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_state", {busy0, rom_en0, h_valid0}, 3'b100);
    chk("mixed_rows", bad_rows(H2_0, 3, 9, 0), 9);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_flags", {h_valid0, load_done0, load_err0, rom_en0}, 0);
    chk("arst_h_mode", h_mode0, 0);
    chk("arst_rom_addr", rom_addr0, 0);
    chk("arst_rows", bad_rows(H2_0, 0, 9, 1), 0);
    @(negedge clk); rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_rows", bad_rows(H2_0, 0, 9, 1), 0);
    chk("post_rst_flags", {busy0, h_valid0}, 0);
    @(negedge clk); c = cyc; load_req0 = 1'b1; load_mode0 = 0; q0.push_back(exp_t'{0, c + 5});
    @(negedge clk); load_req0 = 1'b0;
    repeat (4) @(negedge clk);
    chk("b2b_first_done", load_done0, 1);
    load_req0 = 1'b1; load_mode0 = 3; q0.push_back(exp_t'{3, c + 10});
    @(negedge clk); load_req0 = 1'b0;
    chk("b2b_busy", busy0, 1);
    chk("b2b_h_valid", h_valid0, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("b2b_h_mode", h_mode0, 3);
    chk("b2b_h_valid_end", h_valid0, 1);
    chk("b2b_rows_stable", bad_rows(H2_0, 3, 9, 0), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
